// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/decode/execute sequencing for a subset of the ISA.
// state_dbg encoding: RESET=0, T0..T6=1..7, HALT=8.
module control_sequencer (
  input  logic        Clock,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PC_out,
  output logic        ZLow_out,
  output logic        ZHigh_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        C_out,
  output logic        MDR_out,
  output logic        in_port_out,
  output logic        MAR_enable,
  output logic        Z_enable,
  output logic        PC_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        BA_out,
  output logic        con_in,
  output logic        out_port_enable,
  output logic        RAM_write_enable,
  output logic [4:0]  opcode,
  output logic        Run,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  logic [4:0] op;
  logic       is_alu;
  logic       is_br;

  assign op     = IR[31:27];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_br  = (op == OP_BR);
  assign state_dbg = state;

  always_ff @(posedge Clock) begin
    if (clr) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3: begin
          if (is_alu || is_br) state <= S_T4;
          else if (op == OP_HALT) state <= S_HALT;
          else state <= S_T0;
        end
        S_T4:    state <= S_T5;
        S_T5:    state <= is_br ? S_T6 : S_T0;
        S_T6:    state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Outputs are a pure decode of state and opcode so they line up with the datapath cycle.
  always_comb begin
    PC_out = 1'b0; ZLow_out = 1'b0; ZHigh_out = 1'b0; HI_out = 1'b0;
    LO_out = 1'b0; C_out = 1'b0; MDR_out = 1'b0; in_port_out = 1'b0;
    MAR_enable = 1'b0; Z_enable = 1'b0; PC_enable = 1'b0; MDR_enable = 1'b0;
    IR_enable = 1'b0; Y_enable = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0;
    BA_out = 1'b0; con_in = 1'b0; out_port_enable = 1'b0; RAM_write_enable = 1'b0;
    opcode = 5'b00000;
    Run = (state != S_HALT);
    case (state)
      S_T0: begin PC_out = 1'b1; MAR_enable = 1'b1; end
      S_T1: begin Read = 1'b1; MDR_enable = 1'b1; PC_enable = 1'b1; IncPC = 1'b1; end
      S_T2: begin MDR_out = 1'b1; IR_enable = 1'b1; end
      S_T3: begin
        if (is_alu) begin
          Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; R_out = 1'b1; con_in = 1'b1;
        end else begin
          case (op)
            OP_MFHI: begin HI_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            OP_MFLO: begin LO_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            OP_IN:   begin in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; out_port_enable = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_br) begin
          PC_out = 1'b1; Y_enable = 1'b1;
        end else begin
          Grc = 1'b1; R_out = 1'b1; Z_enable = 1'b1; opcode = op;
        end
      end
      S_T5: begin
        if (is_br) begin
          C_out = 1'b1; Z_enable = 1'b1; opcode = OP_ADD;
        end else begin
          ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end
      end
      // Branch target is taken only when the condition flag is set this cycle.
      S_T6: begin ZLow_out = 1'b1; PC_enable = CON_FF; end
      default: ;
    endcase
  end

endmodule
